// File: rtl/vector_sequencer.sv
// vector_sequencer: stores a bank of CUT input vectors, applies them one at a
// time, waits SETTLE cycles, then hands each captured CUT response downstream.
// Ports: clk/rst_n (async active-low); load_valid/load_ready/load_data/load_exp
// vector write; clear/start control; busy/done/vec_count status; cut_in/cut_out
// CUT drive and response; res_valid/res_ready/res_data/res_index result
// handshake; mismatch/mismatch_count response check.
// Build option: define VECSEQ_COMPARE_EN to add the expected-response memory.
module vector_sequencer #(
    parameter int IN_W   = 36,
    parameter int OUT_W  = 7,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [IN_W-1:0]  load_data,
    input  logic [OUT_W-1:0] load_exp,
    input  logic             clear,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      vec_count,
    output logic [IN_W-1:0]  cut_in,
    input  logic [OUT_W-1:0] cut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic [AW-1:0]    res_index,
    output logic             mismatch,
    output logic [15:0]      mismatch_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESULT,
        S_DONE
    } state_t;

    state_t          state;
    logic [IN_W-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            load_fire;
    logic            last;
    logic            mis_now;

    assign vec_count  = wr_ptr;
    assign load_ready = (state == S_IDLE) && !start && !clear
                        && (wr_ptr < DEPTH_V);
    assign load_fire  = load_valid && load_ready;
    assign last       = ({1'b0, idx} == wr_ptr - (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[wr_ptr[AW-1:0]] <= load_data;
        end
    end

`ifdef VECSEQ_COMPARE_EN
    logic [OUT_W-1:0] exp_mem [DEPTH];
    logic             mis_q;
    logic [15:0]      mcnt_q;

    always_ff @(posedge clk) begin
        if (load_fire) begin
            exp_mem[wr_ptr[AW-1:0]] <= load_exp;
        end
    end

    assign mis_now        = (cut_out != exp_mem[idx]);
    assign mismatch       = mis_q & res_valid;
    assign mismatch_count = mcnt_q;
`else
    logic unused_exp;
    assign unused_exp     = ^load_exp;
    assign mis_now        = 1'b0;
    assign mismatch       = 1'b0;
    assign mismatch_count = 16'h0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cut_in    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_index <= '0;
`ifdef VECSEQ_COMPARE_EN
            mis_q     <= 1'b0;
            mcnt_q    <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (clear) begin
                        wr_ptr <= '0;
                    end else if (start) begin
                        busy <= 1'b1;
                        if (wr_ptr == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx    <= '0;
                            cut_in <= mem[0];
                            cnt    <= CNT_INIT;
`ifdef VECSEQ_COMPARE_EN
                            mcnt_q <= '0;
`endif
                            state  <= S_SETTLE;
                        end
                    end else if (load_fire) begin
                        wr_ptr <= wr_ptr + (AW+1)'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        res_data  <= cut_out;
                        res_index <= idx;
                        res_valid <= 1'b1;
`ifdef VECSEQ_COMPARE_EN
                        mis_q <= mis_now;
                        // count the result as soon as it is presented
                        if (mis_now && mcnt_q != 16'hFFFF) begin
                            mcnt_q <= mcnt_q + 16'd1;
                        end
`endif
                        state <= S_RESULT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx    <= idx + AW'(1);
                            cut_in <= mem[idx + AW'(1)];
                            cnt    <= CNT_INIT;
                            state  <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: table-driven and scoreboard checks of vector_sequencer
// against a small combinational CUT model.
module tb_vector_sequencer;

    localparam int IN_W   = 36;
    localparam int OUT_W  = 7;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 1;
    localparam int AW     = 4;
`ifdef VECSEQ_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_valid;
    logic             load_ready;
    logic [IN_W-1:0]  load_data;
    logic [OUT_W-1:0] load_exp;
    logic             clear;
    logic             start;
    logic             busy;
    logic             done;
    logic [AW:0]      vec_count;
    logic [IN_W-1:0]  cut_in;
    logic [OUT_W-1:0] cut_out;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic [AW-1:0]    res_index;
    logic             mismatch;
    logic [15:0]      mismatch_count;

    vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_exp(load_exp),
        .clear(clear), .start(start),
        .busy(busy), .done(done), .vec_count(vec_count),
        .cut_in(cut_in), .cut_out(cut_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_index(res_index),
        .mismatch(mismatch), .mismatch_count(mismatch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] cut_fn(input logic [IN_W-1:0] v);
        return v[6:0] ^ v[35:29] ^ v[22:16] ^ 7'h2A;
    endfunction

    assign cut_out = cut_fn(cut_in);

    typedef struct {
        logic [IN_W-1:0]  vec;
        logic [OUT_W-1:0] res;
        logic             bad;
    } rec_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [AW-1:0]    idx;
        logic             mis;
    } sb_t;

    rec_t tbl [DEPTH];
    rec_t mrec [DEPTH];
    int   mn;
    sb_t  sb [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_hs = 0;
    int hs_n = 0;
    int done_n = 0;
    bit chk_time = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) done_n++;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got index %0d expected none",
                         res_index);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("res_data", 64'(res_data), 64'(e.data));
                chk("res_index", 64'(res_index), 64'(e.idx));
                chk("mismatch", 64'(mismatch), 64'(e.mis));
                if (chk_time) begin
                    if (res_index == 0)
                        chk("latency", 64'(cyc - start_cyc), 64'(SETTLE));
                    else
                        chk("period", 64'(cyc - last_hs), 64'(SETTLE + 1));
                end
            end
            last_hs = cyc;
            hs_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i);
        int prev;
        prev       = int'(vec_count);
        load_data  = tbl[i].vec;
        load_exp   = tbl[i].res ^ {6'b0, tbl[i].bad};
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("vec_count_inc", 64'(vec_count), 64'(prev + 1));
        mrec[mn] = tbl[i];
        mn++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_count", 64'(vec_count), 64'd0);
        mn = 0;
    endtask

    task automatic kick();
        for (int i = 0; i < mn; i++) begin
            sb.push_back('{data: mrec[i].res, idx: AW'(i),
                           mis: CMP & mrec[i].bad});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd1);
        step();
        chk("done_pulse", 64'(done), 64'd0);
        chk("busy_fall", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int h0;
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 3) tbl[i].vec = IN_W'(i + 1);
            else tbl[i].vec = 36'h9_8765_4321 ^ (IN_W'(i) * 36'h1_0203_0405);
            tbl[i].res = cut_fn(tbl[i].vec);
            tbl[i].bad = (i == 1 || i == 3);
        end
        mn = 0;
        rst_n = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        load_exp = '0;
        clear = 1'b0;
        start = 1'b0;
        res_ready = 1'b1;
        repeat (2) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_count", 64'(vec_count), 64'd0);
        chk("rst_cut_in", 64'(cut_in), 64'd0);
        chk("rst_mcount", 64'(mismatch_count), 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // three vectors, ready always high
        for (int i = 0; i < 3; i++) load(i);
        d0 = done_n;
        h0 = hs_n;
        chk_time = 1'b1;
        kick();
        wait_done(100);
        chk_time = 1'b0;
        chk("t1_done_once", 64'(done_n - d0), 64'd1);
        chk("t1_results", 64'(hs_n - h0), 64'd3);
        chk("t1_count_kept", 64'(vec_count), 64'd3);
        chk("t1_cut_in_last", 64'(cut_in), 64'(tbl[2].vec));

        // fill to DEPTH and try one more
        do_clear();
        for (int i = 0; i < DEPTH; i++) load(i);
        chk("full_ready", 64'(load_ready), 64'd0);
        load_data = 36'hF_FFFF_FFFF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("full_count", 64'(vec_count), 64'(DEPTH));
        h0 = hs_n;
        chk_time = 1'b1;
        kick();
        wait_done(200);
        chk_time = 1'b0;
        chk("full_results", 64'(hs_n - h0), 64'(DEPTH));
        chk("full_cut_in", 64'(cut_in), 64'(tbl[DEPTH-1].vec));
        do_clear();

        // empty run
        d0 = done_n;
        h0 = hs_n;
        kick();
        chk("empty_busy", 64'(busy), 64'd1);
        chk("empty_done", 64'(done), 64'd1);
        step();
        chk("empty_busy_fall", 64'(busy), 64'd0);
        chk("empty_done_fall", 64'(done), 64'd0);
        chk("empty_pulses", 64'(done_n - d0), 64'd1);
        chk("empty_results", 64'(hs_n - h0), 64'd0);

        // stall on vector 1
        for (int i = 0; i < 3; i++) load(i);
        h0 = hs_n;
        kick();
        n = 0;
        while (!(res_valid && res_index == 1) && n < 50) begin
            step();
            n++;
        end
        res_ready = 1'b0;
        chk("stall_reached", 64'(res_index), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", 64'(res_valid), 64'd1);
            chk("stall_data", 64'(res_data), 64'(tbl[1].res));
            chk("stall_index", 64'(res_index), 64'd1);
            chk("stall_cut_in", 64'(cut_in), 64'(tbl[1].vec));
        end
        res_ready = 1'b1;
        step();
        chk("release_cut_in", 64'(cut_in), 64'(tbl[2].vec));
        chk("release_valid", 64'(res_valid), 64'd0);
        wait_done(50);
        chk("stall_results", 64'(hs_n - h0), 64'd3);

        // reset during SETTLE of vector 2
        kick();
        n = 0;
        while (!(cut_in == tbl[2].vec && !res_valid) && n < 50) begin
            step();
            n++;
        end
        chk("rst_reach", 64'(cut_in), 64'(tbl[2].vec));
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_valid", 64'(res_valid), 64'd0);
        chk("mid_count", 64'(vec_count), 64'd0);
        chk("mid_cut_in", 64'(cut_in), 64'd0);
        chk("mid_data", 64'(res_data), 64'd0);
        chk("mid_index", 64'(res_index), 64'd0);
        chk("mid_mcount", 64'(mismatch_count), 64'd0);
        sb.delete();
        mn = 0;
        step();
        rst_n = 1'b1;
        step();
        d0 = done_n;
        h0 = hs_n;
        kick();
        wait_done(10);
        chk("post_rst_pulses", 64'(done_n - d0), 64'd1);
        chk("post_rst_results", 64'(hs_n - h0), 64'd0);

        // response compare, two wrong expectations
        for (int i = 0; i < 4; i++) load(i);
        for (int r = 0; r < 2; r++) begin
            kick();
            chk("mc_restart", 64'(mismatch_count), 64'd0);
            n = 0;
            while (!done && n < 100) begin
                step();
                n++;
            end
            chk("mc_at_done", 64'(mismatch_count), CMP ? 64'd2 : 64'd0);
            wait_done(5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
